pmem_burst_adapter: RTL
=======================

// Module: pmem_burst_adapter
// PURPOSE
//  Responder end of the L2 pmem_* line interface. Accepts one 256-bit line read or write per transaction
//  and runs it on the 64-bit burst memory bus as 4 beats, then pulses line_resp.
//  Sits between L2Cache (pmem_* outputs) and physical memory; one transaction in flight, no caching.
// PARAMETERS
//  LINE_W    256   line width in bits (matches L2 s_line)
//  BEAT_W    64    burst data width in bits
//  BEATS     4     LINE_W/BEAT_W; beats per line, must be a power of two
//  ADDR_W    32    address width
//  OFFSET_W  5     line-offset bits forced to zero on burst_address
// PORTS
//  clk            in   1       clock, all state on rising edge
//  rst            in   1       asynchronous, active-low reset (rst==0 resets)
//  line_address   in   ADDR_W  line address from L2 (pmem_address)
//  line_read      in   1       line read request, held until line_resp
//  line_write     in   1       line write request, held until line_resp
//  line_wdata     in   LINE_W  write line (pmem_wdata)
//  line_rdata     out  LINE_W  read line (pmem_rdata), valid when line_resp=1
//  line_resp      out  1       one-cycle completion pulse (pmem_resp)
//  burst_address  out  ADDR_W  line-aligned burst address
//  burst_read     out  1       burst read, held until final beat
//  burst_write    out  1       burst write, held until final beat
//  burst_wdata    out  BEAT_W  current write beat
//  burst_rdata    in   BEAT_W  current read beat
//  burst_resp     in   1       beat strobe: one beat moves in each cycle it is high; gaps allowed
// BEHAVIOUR
//  Reset (async, rst==0): state IDLE, beat_cnt=0. All outputs 0, including line_rdata and burst_address.
//  States: IDLE -> RD | WR -> DONE -> IDLE.
//  IDLE: line_write=1 -> WR (write wins if both are high). Else line_read=1 -> RD.
//    On accept: latch {line_address[ADDR_W-1:OFFSET_W], OFFSET_W'0} into burst_address; latch line_wdata into buffer.
//    burst_resp is ignored in IDLE and DONE.
//  RD: burst_read=1, burst_address stable. Each cycle burst_resp=1: buf[beat_cnt*BEAT_W +: BEAT_W] <= burst_rdata, beat_cnt++.
//  WR: burst_write=1, burst_wdata = buf[beat_cnt*BEAT_W +: BEAT_W] (combinational from beat_cnt). Advance on burst_resp.
//  Last beat (beat_cnt==BEATS-1 && burst_resp): beat_cnt wraps to 0. Go to DONE.
//    burst_read/burst_write deassert the next cycle; never held past the last beat.
//  DONE: line_resp=1 for exactly one cycle. line_rdata = buf; holds until the next read's DONE.
//    Requests are not sampled in DONE. Back-to-back: request still high in the cycle after DONE starts a new transaction.
//  Latency: accept at cycle 0, burst command cycles 1..; beats at k..k+3 -> line_resp at cycle k+4. Minimum 6 cycles.
//  line_address/line_wdata changes after accept have no effect on the transaction in flight.
//  Dropping line_read/line_write mid-burst is a protocol violation. Burst still completes, line_resp still pulses.
//  Reset mid-burst: immediate abort, all outputs 0, no line_resp; a partial buffer is not exposed.
// STRUCTURE
//  Package cacheline_pkg: LINE_W, BEAT_W, BEATS, OFFSET_W constants; adapter_state_t enum {IDLE,RD,WR,DONE}.
//  One sub-module: line_beat_buffer. Holds the LINE_W register and exposes beat-indexed write-in, beat-indexed
//  read-out and whole-line load. FSM and $clog2(BEATS)-bit beat counter stay in the top module.
// TESTING
//  Read, resp on 4 consecutive cycles, beats 64'h0..00,..11,..22,..33, addr 32'h0000_1234
//    -> burst_address=32'h0000_1220; line_rdata=256'h33..22..11..00 with beat 0 in the LSBs; one line_resp;
//    burst_read low the cycle after beat 3.
//  Write line_wdata=256'hDDDD..CCCC..BBBB..AAAA with gaps (resp 1,0,1,0,0,1,1)
//    -> burst_wdata AAAA,BBBB,CCCC,DDDD in order; each beat held across gaps.
//  Read and write asserted together -> WR taken; burst_read never asserted.
//  rst=0 during beat 2 of a read -> outputs 0 immediately; no line_resp.
//    After release, a new read completes with correct data.
//  Back-to-back write then read, requests held through resp -> two line_resp pulses.
//    Second burst starts the cycle after DONE; beat_cnt starts at 0.
//  burst_resp pulsed while IDLE -> no state change, no line_resp, line_rdata unchanged.

Source files
------------

// File: rtl/cacheline_pkg.sv
// Shared line/beat geometry and FSM state type for the pmem line-to-burst adapter.
package cacheline_pkg;
  localparam int LINE_W   = 256;
  localparam int BEAT_W   = 64;
  localparam int BEATS    = LINE_W / BEAT_W;
  localparam int ADDR_W   = 32;
  localparam int OFFSET_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } adapter_state_t;
endpackage

// File: rtl/line_beat_buffer.sv
// One cache line of storage, loadable whole or one beat at a time, with a beat-indexed read port.
module line_beat_buffer
  import cacheline_pkg::*;
#(
  parameter int L_W   = LINE_W,
  parameter int B_W   = BEAT_W,
  parameter int NB    = L_W / B_W,
  parameter int IDX_W = $clog2(NB)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [L_W-1:0]   load_line,
  input  logic             beat_we,
  input  logic [IDX_W-1:0] beat_idx,
  input  logic [B_W-1:0]   beat_in,
  output logic [B_W-1:0]   beat_out,
  output logic [L_W-1:0]   line
);
  localparam int BASE_W = $clog2(L_W);
  localparam int SHIFT  = $clog2(B_W);

  // Beat count and beat width are powers of two, so the bit offset is a plain concatenation.
  logic [BASE_W-1:0] base;
  assign base = {beat_idx, {SHIFT{1'b0}}};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      line <= '0;
    end else if (load) begin
      line <= load_line;
    end else if (beat_we) begin
      line[base +: B_W] <= beat_in;
    end
  end

  assign beat_out = line[base +: B_W];
endmodule

// File: rtl/pmem_burst_adapter.sv
// Runs one 256-bit pmem line read/write as a 4-beat 64-bit memory burst, then pulses line_resp.
//   state | meaning
//   IDLE  | waiting for line_read/line_write; write wins when both are high
//   RD    | burst_read held, beats captured into the line buffer on burst_resp
//   WR    | burst_write held, beats driven from the line buffer, advance on burst_resp
//   DONE  | one-cycle line_resp; requests are not sampled here
module pmem_burst_adapter
  import cacheline_pkg::*;
#(
  parameter int P_LINE_W   = LINE_W,
  parameter int P_BEAT_W   = BEAT_W,
  parameter int P_BEATS    = P_LINE_W / P_BEAT_W,
  parameter int P_ADDR_W   = ADDR_W,
  parameter int P_OFFSET_W = OFFSET_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [P_ADDR_W-1:0]   line_address,
  input  logic                  line_read,
  input  logic                  line_write,
  input  logic [P_LINE_W-1:0]   line_wdata,
  output logic [P_LINE_W-1:0]   line_rdata,
  output logic                  line_resp,
  output logic [P_ADDR_W-1:0]   burst_address,
  output logic                  burst_read,
  output logic                  burst_write,
  output logic [P_BEAT_W-1:0]   burst_wdata,
  input  logic [P_BEAT_W-1:0]   burst_rdata,
  input  logic                  burst_resp
);
  localparam int CNT_W = $clog2(P_BEATS);

  adapter_state_t      state, state_nx;
  logic [CNT_W-1:0]    beat_cnt;
  logic                is_rd;
  logic                accept, advance, last_beat, beat_we;
  logic [P_LINE_W-1:0] buf_line, rdata_q;
  logic [P_BEAT_W-1:0] buf_beat;
  logic                unused_offset;

  assign unused_offset = ^line_address[P_OFFSET_W-1:0];
  assign last_beat     = (beat_cnt == CNT_W'(P_BEATS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    accept      = 1'b0;
    advance     = 1'b0;
    beat_we     = 1'b0;
    burst_read  = 1'b0;
    burst_write = 1'b0;
    burst_wdata = '0;
    line_resp   = 1'b0;
    case (state)
      IDLE: begin
        if (line_write) begin
          state_nx = WR;
          accept   = 1'b1;
        end else if (line_read) begin
          state_nx = RD;
          accept   = 1'b1;
        end
      end
      RD: begin
        burst_read = 1'b1;
        if (burst_resp) begin
          advance = 1'b1;
          beat_we = 1'b1;
          if (last_beat) state_nx = DONE;
        end
      end
      WR: begin
        burst_write = 1'b1;
        burst_wdata = buf_beat;
        if (burst_resp) begin
          advance = 1'b1;
          if (last_beat) state_nx = DONE;
        end
      end
      DONE: begin
        line_resp = 1'b1;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_cnt <= '0;
    end else if (advance) begin
      beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      burst_address <= '0;
      is_rd         <= 1'b0;
    end else if (accept) begin
      burst_address <= {line_address[P_ADDR_W-1:P_OFFSET_W], {P_OFFSET_W{1'b0}}};
      is_rd         <= !line_write;
    end
  end

  // The buffer is shared by reads and writes, so the visible read line is kept separately
  // and only refreshed once a read has filled every beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= '0;
    end else if (state == DONE && is_rd) begin
      rdata_q <= buf_line;
    end
  end

  assign line_rdata = (state == DONE && is_rd) ? buf_line : rdata_q;

  line_beat_buffer #(
    .L_W (P_LINE_W),
    .B_W (P_BEAT_W),
    .NB  (P_BEATS)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .load_line (line_wdata),
    .beat_we   (beat_we),
    .beat_idx  (beat_cnt),
    .beat_in   (burst_rdata),
    .beat_out  (buf_beat),
    .line      (buf_line)
  );
endmodule
